div_seq: RTL

- Iterative radix-2 restoring divider with its own sequencing FSM, for the MIPS DIV/DIVU path.
- Decode asserts start when a divide issues. The block holds the pipeline through stall_req until the quotient and remainder are ready.
- The HI/LO write-back logic consumes those results on the done pulse.
- The cancel input (exception flush) aborts an in-flight divide.

---
 rtl/div_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// div_seq: iterative radix-2 restoring divider for MIPS DIV/DIVU with stall/done handshake.
// Define DIV_ZERO_FAST_EN to finish a zero-divisor request in one cycle with raw results.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             stall_req,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic             accept, dvd_neg, dsr_neg, fits;
    logic [WIDTH-1:0] dvd_mag, dsr_mag, step_rem, step_quo;
    logic [WIDTH:0]   shifted, trial;

    assign accept   = start & ~cancel & (state_q == S_IDLE | state_q == S_DONE);
    assign dvd_neg  = signed_op & dividend[WIDTH-1];
    assign dsr_neg  = signed_op & divisor[WIDTH-1];
    assign dvd_mag  = dvd_neg ? -dividend : dividend;
    assign dsr_mag  = dsr_neg ? -divisor : divisor;
    // work_q holds the dividend bits still to shift in; quotient bits fill from the bottom
    assign shifted  = {prem_q, work_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dsr_q};
    assign fits     = ~trial[WIDTH];
    assign step_rem = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign step_quo = {work_q[WIDTH-2:0], fits};

    assign stall_req = accept | (state_q == S_RUN);
    assign busy      = state_q == S_RUN;
    assign done      = state_q == S_DONE;
    assign quotient  = quot_q;
    assign remainder = rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        work_d  = work_q;
        dsr_d   = dsr_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        if (cancel) begin
            state_d = S_IDLE;
        end else if (accept) begin
            state_d = S_RUN;
            cnt_d   = CNT_W'(WIDTH);
            prem_d  = '0;
            work_d  = dvd_mag;
            dsr_d   = dsr_mag;
            negq_d  = dvd_neg ^ dsr_neg;
            negr_d  = dvd_neg;
`ifdef DIV_ZERO_FAST_EN
            if (divisor == '0) begin
                state_d = S_DONE;
                quot_d  = '1;
                rem_d   = dividend;
            end
`endif
        end else if (state_q == S_RUN) begin
            prem_d = step_rem;
            work_d = step_quo;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = S_DONE;
                quot_d  = negq_q ? -step_quo : step_quo;
                rem_d   = negr_q ? -step_rem : step_rem;
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            work_q  <= '0;
            dsr_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            work_q  <= work_d;
            dsr_q   <= dsr_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end
endmodule
